// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: key debounce, game FSM, tick divider, score and lives.
// Optional PONG_SPEEDUP_EN: tick period shortens as paddle hits accumulate.
module pong_game_ctrl #(
    parameter int unsigned TICK_DIV     = 262144,
    parameter int unsigned MIN_DIV      = 65536,
    parameter int unsigned SPEEDUP_HITS = 4,
    parameter int unsigned DEB_CYCLES   = 500000,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               key_start_n,
    input  logic               paddle_hit,
    input  logic               ball_lost,
    output logic               game_tick,
    output logic               serve,
    output logic               show_pause,
    output logic               show_over,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [2:0]         state
);

    localparam int DIV_W = $clog2(TICK_DIV) + 2;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_BASE = DIV_W'(TICK_DIV);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_MISS  = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    logic               sync1_q, sync2_q;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic               press;
    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               serve_q, serve_d;
    logic               pause_q, pause_d;
    logic               over_q, over_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [DIV_W-1:0]   div_cur;
    logic               wrap;

`ifdef PONG_SPEEDUP_EN
    localparam int HIT_W = $clog2(SPEEDUP_HITS + 1);
    localparam logic [DIV_W-1:0] DIV_STEP = DIV_W'(TICK_DIV / 8);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);
    localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(SPEEDUP_HITS - 1);

    logic [DIV_W-1:0] div_q, div_d, tgt_q, tgt_d;
    logic [HIT_W-1:0] hits_q, hits_d;
    logic             restart, hit_ok;

    assign div_cur = div_q;
    assign restart = (state_q == S_IDLE || state_q == S_OVER)
                     && state_d == S_SERVE;
    assign hit_ok = state_q == S_PLAY && state_d == S_PLAY && paddle_hit;

    // Speed target steps down every SPEEDUP_HITS hits; active div loads at wrap/serve
    always_comb begin
        tgt_d  = tgt_q;
        hits_d = hits_q;
        div_d  = div_q;
        if (restart) begin
            tgt_d  = DIV_BASE;
            hits_d = '0;
        end else if (hit_ok) begin
            if (hits_q == HIT_LAST) begin
                hits_d = '0;
                tgt_d  = (tgt_q >= DIV_MIN + DIV_STEP) ? tgt_q - DIV_STEP
                                                       : DIV_MIN;
            end else begin
                hits_d = hits_q + HIT_W'(1);
            end
        end
        if (state_d == S_SERVE || (state_d == S_PLAY && wrap))
            div_d = tgt_d;
    end

    // Speed-up state registers
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            div_q  <= DIV_BASE;
            tgt_q  <= DIV_BASE;
            hits_q <= '0;
        end else begin
            div_q  <= div_d;
            tgt_q  <= tgt_d;
            hits_q <= hits_d;
        end
    end
`else
    assign div_cur = DIV_BASE;
`endif

    assign wrap  = (cnt_q == div_cur - DIV_W'(1));
    assign press = !sync2_q && (deb_q == DEB_LAST);

    // Stable-low counter; press fires once when the count reaches DEB_CYCLES
    always_comb begin
        deb_d = deb_q;
        if (sync2_q)
            deb_d = '0;
        else if (deb_q != DEB_MAX)
            deb_d = deb_q + DEB_W'(1);
    end

    // Game FSM next state, score and lives
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        unique case (state_q)
            S_IDLE: if (press) state_d = S_SERVE;
            S_SERVE: state_d = S_PLAY;
            S_PLAY: begin
                if (ball_lost) begin
                    state_d = S_MISS;
                    lives_d = lives_q - 2'd1;
                end else if (press) begin
                    state_d = S_PAUSE;
                end else if (paddle_hit && score_q != '1) begin
                    score_d = score_q + SCORE_W'(1);
                end
            end
            S_PAUSE: if (press) state_d = S_PLAY;
            S_MISS: state_d = (lives_q == 2'd0) ? S_OVER : S_SERVE;
            S_OVER: begin
                if (press) begin
                    state_d = S_SERVE;
                    score_d = '0;
                    lives_d = 2'(LIVES);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tick divider runs only on cycles that end in PLAY; outputs follow next state
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (state_d == S_SERVE) begin
            cnt_d = '0;
        end else if (state_d == S_PLAY) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        serve_d = (state_d == S_SERVE);
        pause_d = (state_d == S_IDLE) || (state_d == S_PAUSE);
        over_d  = (state_d == S_OVER);
    end

    // All state and output registers
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            serve_q <= 1'b0;
            pause_q <= 1'b1;
            over_q  <= 1'b0;
            score_q <= '0;
            lives_q <= 2'(LIVES);
        end else begin
            sync1_q <= key_start_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            serve_q <= serve_d;
            pause_q <= pause_d;
            over_q  <= over_d;
            score_q <= score_d;
            lives_q <= lives_d;
        end
    end

    assign game_tick  = tick_q;
    assign serve      = serve_q;
    assign show_pause = pause_q;
    assign show_over  = over_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: vector table, hand sequences and random hits.
// Builds with or without PONG_SPEEDUP_EN.
module tb_pong_game_ctrl;

    localparam int TICK = 8;
    localparam int MIND = 6;
    localparam int NHIT = 4;
    localparam int DEB  = 4;
    localparam int LIV  = 3;
    localparam int SW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_n = 1'b1;
    logic          hit = 1'b0;
    logic          lost = 1'b0;
    logic          game_tick, serve, show_pause, show_over;
    logic [SW-1:0] score;
    logic [1:0]    lives;
    logic [2:0]    state;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .TICK_DIV(TICK), .MIN_DIV(MIND), .SPEEDUP_HITS(NHIT),
        .DEB_CYCLES(DEB), .LIVES(LIV), .SCORE_W(SW)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .key_start_n(key_n),
        .paddle_hit(hit), .ball_lost(lost), .game_tick(game_tick),
        .serve(serve), .show_pause(show_pause), .show_over(show_over),
        .score(score), .lives(lives), .state(state)
    );

    typedef struct {
        logic key;
        logic hit;
        int   st;
        int   srv;
        int   tk;
        int   sc;
    } vec_t;

    vec_t tbl [14];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ticks_total = 0;
    int bad_ticks = 0;
    int serve_cnt = 0;
    int last_serve = 0;
    int last_tick = 0;
    int play_since = 0;
    int last_gap = 0;

    function automatic vec_t mk(logic k, logic h, int st, int sv, int tk, int sc);
        vec_t v;
        v.key = k; v.hit = h; v.st = st; v.srv = sv; v.tk = tk; v.sc = sc;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // one clock; observe outputs 1ns after the edge and update the tick model
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (serve) begin
            serve_cnt++;
            last_serve = cyc;
            play_since = 0;
        end
        if (state == 3'd2) play_since++;
        if (game_tick) begin
            ticks_total++;
            last_tick = cyc;
            last_gap = play_since;
            play_since = 0;
            if (state != 3'd2 || serve) bad_ticks++;
        end
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        repeat (2) step();
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_pause"}, int'(show_pause), 1);
        chk({tag, "_over"}, int'(show_over), 0);
        chk({tag, "_serve"}, int'(serve), 0);
        chk({tag, "_tick"}, int'(game_tick), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_lives"}, int'(lives), LIV);
        rst_n = 1'b1;
        play_since = 0;
    endtask

    task automatic press();
        key_n = 1'b0;
        repeat (6) step();
        key_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic wait_tick(string name, output int at);
        int n = 0;
        do begin
            step();
            n++;
        end while (!game_tick && n < 64);
        if (!game_tick) chk({name, "_timeout"}, 0, 1);
        at = cyc;
    endtask

    initial begin
        int t0, r, ta, tb, s0, n, exp_p;

        tbl[0]  = mk(0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 1, 0, 0);
        tbl[6]  = mk(1, 0, 2, 0, 0, 0);
        tbl[7]  = mk(1, 0, 2, 0, 0, 0);
        tbl[8]  = mk(1, 0, 2, 0, 0, 0);
        tbl[9]  = mk(1, 1, 2, 0, 0, 1);
        tbl[10] = mk(1, 0, 2, 0, 0, 1);
        tbl[11] = mk(1, 0, 2, 0, 0, 1);
        tbl[12] = mk(1, 0, 2, 0, 0, 1);
        tbl[13] = mk(1, 0, 2, 0, 1, 1);

        do_reset("rst");

        // idle with key released
        repeat (100) step();
        chk("idle_state", int'(state), 0);
        chk("idle_pause", int'(show_pause), 1);
        chk("idle_ticks", ticks_total, 0);
        chk("idle_lives", int'(lives), LIV);
        chk("idle_score", int'(score), 0);

        // bouncing key: low runs shorter than the debounce window
        for (int i = 0; i < 10; i++) begin
            key_n = 1'b0;
            repeat ($urandom_range(1, 2)) step();
            key_n = 1'b1;
            step();
        end
        repeat (4) step();
        chk("bounce_state", int'(state), 0);
        chk("bounce_serves", serve_cnt, 0);

        // table: press, serve, first hit, first tick
        for (int i = 0; i < 14; i++) begin
            key_n = tbl[i].key;
            hit = tbl[i].hit;
            step();
            chk($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("vec%0d_serve", i), int'(serve), tbl[i].srv);
            chk($sformatf("vec%0d_tick", i), int'(game_tick), tbl[i].tk);
            chk($sformatf("vec%0d_score", i), int'(score), tbl[i].sc);
        end
        hit = 1'b0;
        wait_tick("tick2", ta);
        chk("tick2_ofs", ta - last_serve, 2 * TICK);
        wait_tick("tick3", ta);
        chk("tick3_ofs", ta - last_serve, 3 * TICK);

        // pause freezes the divider phase
        step();
        key_n = 1'b0;
        repeat (6) step();
        key_n = 1'b1;
        chk("pause_state", int'(state), 3);
        chk("pause_overlay", int'(show_pause), 1);
        t0 = ticks_total;
        repeat (20) step();
        chk("pause_ticks", ticks_total - t0, 0);
        chk("pause_hold", int'(state), 3);
        key_n = 1'b0;
        repeat (6) step();
        key_n = 1'b1;
        r = cyc;
        chk("resume_state", int'(state), 2);
        repeat (12) step();
        chk("resume_ticks", ticks_total - t0, 2);
        chk("resume_last", last_tick - r, 1 + TICK);
        chk("resume_gap", last_gap, TICK);

        // three misses, lost pulses during MISS/SERVE ignored
        for (int k = 1; k <= 3; k++) begin
            lost = 1'b1;
            step();
            chk($sformatf("miss%0d_state", k), int'(state), 4);
            chk($sformatf("miss%0d_lives", k), int'(lives), LIV - k);
            step();
            lost = 1'b0;
            if (k < 3) begin
                chk($sformatf("miss%0d_serve", k), int'(serve), 1);
                chk($sformatf("miss%0d_st1", k), int'(state), 1);
                lost = 1'b1;
                step();
                lost = 1'b0;
                chk($sformatf("miss%0d_play", k), int'(state), 2);
                chk($sformatf("miss%0d_lives2", k), int'(lives), LIV - k);
            end
        end
        chk("over_state", int'(state), 5);
        chk("over_flag", int'(show_over), 1);
        chk("over_serve", int'(serve), 0);
        t0 = ticks_total;
        lost = 1'b1;
        repeat (10) step();
        lost = 1'b0;
        chk("over_ticks", ticks_total - t0, 0);
        chk("over_score", int'(score), 1);
        chk("over_lives", int'(lives), 0);
        s0 = serve_cnt;
        press();
        chk("newgame_serves", serve_cnt - s0, 1);
        chk("newgame_state", int'(state), 2);
        chk("newgame_score", int'(score), 0);
        chk("newgame_lives", int'(lives), LIV);

        // hit and lost together: lost wins
        hit = 1'b1;
        lost = 1'b1;
        step();
        hit = 1'b0;
        lost = 1'b0;
        chk("both_state", int'(state), 4);
        chk("both_score", int'(score), 0);
        chk("both_lives", int'(lives), LIV - 1);
        repeat (2) step();
        chk("both_replay", int'(state), 2);

        // random hit stream, score saturates
        n = 0;
        while (n < 300) begin
            hit = 1'($urandom_range(0, 1));
            if (hit) n++;
            step();
            if (hit && (n % 60 == 0))
                chk($sformatf("score_at_%0d", n), int'(score), (n > 255) ? 255 : n);
            hit = 1'b0;
        end
        step();
        chk("score_sat", int'(score), 255);

        // reset mid-game, then tick period versus hit count
        do_reset("midrst");
        repeat (4) step();
        press();
        chk("speed_state", int'(state), 2);
        for (int g = 1; g <= 3; g++) begin
            hit = 1'b1;
            repeat (NHIT) step();
            hit = 1'b0;
            wait_tick($sformatf("sp%0da", g), ta);
            wait_tick($sformatf("sp%0db", g), tb);
`ifdef PONG_SPEEDUP_EN
            exp_p = TICK - ((g * NHIT) / NHIT) * (TICK / 8);
            if (exp_p < MIND) exp_p = MIND;
`else
            exp_p = TICK;
`endif
            chk($sformatf("period_after_%0d_hits", g * NHIT), tb - ta, exp_p);
        end

        chk("tick_legality", bad_ticks, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
